// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: state numbers, opcodes,
// ALU/mux select codes and the decoded control word.
package mips_ctrl_pkg;

  localparam int OP_W    = 6;
  localparam int STATE_W = 4;

  // State numbering keeps TRAP at 11; JEX takes the next free code, 13..15 are unencoded.
  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] RTYPEEX = 4'd6;
  localparam logic [3:0] RTYPEWB = 4'd7;
  localparam logic [3:0] BEQEX   = 4'd8;
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] ADDIWB  = 4'd10;
  localparam logic [3:0] TRAP    = 4'd11;
  localparam logic [3:0] JEX     = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // *_req bits still need the mem_ready qualification applied by the controller.
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite_req;
    logic       pcwrite_req;
    logic       pcwrite;
    logic       branch;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_word_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
interface multicycle_ctrl_if #(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
);
  // mem_ready is a completion strobe, not a valid/ready pair: the controller holds
  // its access (iord/memwrite) steady and treats the access as done in the cycle
  // mem_ready=1; mem_ready is ignored in every state that makes no memory access.
  logic [OP_W-1:0]    op;
  logic               zero;
  logic               mem_ready;
  logic               pcen;
  logic               iord;
  logic               memwrite;
  logic               irwrite;
  logic               regdst;
  logic               memtoreg;
  logic               regwrite;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic [1:0]         pcsrc;
  logic [1:0]         aluop;
  logic               illegal;
  logic [STATE_W-1:0] state;

  modport master (
    input  op, zero, mem_ready,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, aluop, illegal, state
  );

  modport slave (
    output op, zero, mem_ready,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, aluop, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl_outdec.sv
// Combinational state -> control-word decoder; the whole word is forced to 0 while reset=0.
module mc_outdec
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               reset,
  input  logic [STATE_W-1:0] state,
  output ctrl_word_t         cw
);

  always_comb begin
    cw = '0;
    case (state)
      FETCH: begin
        cw.alusrcb     = ALUSRCB_FOUR;
        cw.aluop       = ALUOP_ADD;
        cw.irwrite_req = 1'b1;
        cw.pcwrite_req = 1'b1;
      end
      DECODE: begin
        cw.alusrcb = ALUSRCB_IMMSH;
        cw.aluop   = ALUOP_ADD;
      end
      MEMADR: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = ALUSRCB_IMM;
        cw.aluop   = ALUOP_ADD;
      end
      MEMRD: cw.iord = 1'b1;
      MEMWB: begin
        cw.memtoreg = 1'b1;
        cw.regwrite = 1'b1;
      end
      MEMWR: begin
        cw.iord     = 1'b1;
        cw.memwrite = 1'b1;
      end
      RTYPEEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = ALUSRCB_B;
        cw.aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        cw.regdst   = 1'b1;
        cw.regwrite = 1'b1;
      end
      BEQEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = ALUSRCB_B;
        cw.aluop   = ALUOP_SUB;
        cw.pcsrc   = PCSRC_ALUOUT;
        cw.branch  = 1'b1;
      end
      ADDIEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = ALUSRCB_IMM;
        cw.aluop   = ALUOP_ADD;
      end
      ADDIWB: cw.regwrite = 1'b1;
      JEX: begin
        cw.pcsrc   = PCSRC_JUMP;
        cw.pcwrite = 1'b1;
      end
      TRAP:    cw.illegal = 1'b1;
      default: cw = '0;
    endcase
    // Applied after decode so reset kills every write in the cycle it falls.
    if (!reset) begin
      cw = '0;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: state register, next-state rules,
// and mem_ready/zero qualification of the PC and IR enables.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W            = 6,
  parameter int STATE_W         = 4,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  logic [STATE_W-1:0] state_q;
  logic [OP_W-1:0]    op;
  ctrl_word_t         cw;

  assign op = bus.op;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (bus.mem_ready) begin
            state_q <= DECODE;
          end
        end
        DECODE: begin
          if (op == OP_RTYPE) begin
            state_q <= RTYPEEX;
          end else if (is_mem_op(op)) begin
            state_q <= MEMADR;
          end else if (op == OP_BEQ) begin
            state_q <= BEQEX;
          end else if (op == OP_ADDI) begin
            state_q <= ADDIEX;
          end else if (op == OP_J) begin
            state_q <= JEX;
          end else begin
            state_q <= (TRAP_ON_ILLEGAL != 0) ? TRAP : FETCH;
          end
        end
        MEMADR: begin
          if (op == OP_LW) begin
            state_q <= MEMRD;
          end else if (op == OP_SW) begin
            state_q <= MEMWR;
          end else begin
            state_q <= FETCH;
          end
        end
        MEMRD: begin
          if (bus.mem_ready) begin
            state_q <= MEMWB;
          end
        end
        MEMWB:   state_q <= FETCH;
        MEMWR: begin
          if (bus.mem_ready) begin
            state_q <= FETCH;
          end
        end
        RTYPEEX: state_q <= RTYPEWB;
        RTYPEWB: state_q <= FETCH;
        BEQEX:   state_q <= FETCH;
        ADDIEX:  state_q <= ADDIWB;
        ADDIWB:  state_q <= FETCH;
        JEX:     state_q <= FETCH;
        TRAP:    state_q <= TRAP;
        default: state_q <= FETCH;
      endcase
    end
  end

  mc_outdec #(
    .STATE_W (STATE_W)
  ) u_outdec (
    .reset (reset),
    .state (state_q),
    .cw    (cw)
  );

  // The fetch-side writes only land in the cycle the instruction word arrives.
  assign bus.pcen     = (cw.pcwrite_req & bus.mem_ready) | cw.pcwrite | (cw.branch & bus.zero);
  assign bus.irwrite  = cw.irwrite_req & bus.mem_ready;
  assign bus.iord     = cw.iord;
  assign bus.memwrite = cw.memwrite;
  assign bus.regdst   = cw.regdst;
  assign bus.memtoreg = cw.memtoreg;
  assign bus.regwrite = cw.regwrite;
  assign bus.alusrca  = cw.alusrca;
  assign bus.alusrcb  = cw.alusrcb;
  assign bus.pcsrc    = cw.pcsrc;
  assign bus.aluop    = cw.aluop;
  assign bus.illegal  = cw.illegal;
  assign bus.state    = state_q;

endmodule
